// File: rtl/axil_ctrl_regs_if.sv
// AXI-Lite control-port bundle between a bus master and the accelerator register file.
// Combinational wiring only; the master drives VALIDs, the slave drives READYs and responses.
interface axil_ctrl_regs_if;
    logic [31:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axil_ctrl_regs.sv
// AXI-Lite register file: CTRL/start, STATUS, W1C IRQ_STAT, IRQ_EN and NREG GP registers.
// Write commits one cycle after BVALID rises and waits on BREADY; reads return in 2 cycles and hold for RREADY.
module axil_ctrl_regs #(
    parameter int NREG   = 8,
    parameter int STAT_W = 8,
    parameter int IRQ_N  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    axil_ctrl_regs_if.slave      s_axi,
    output logic [2:0]           ctrl,
    output logic                 start,
    output logic [32*NREG-1:0]   gp_regs,
    input  logic [STAT_W-1:0]    status_in,
    input  logic [IRQ_N-1:0]     irq_src,
    output logic                 irq
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WA   = 3'd1;
    localparam logic [2:0] WD   = 3'd2;
    localparam logic [2:0] B    = 3'd3;
    localparam logic [2:0] R1   = 3'd4;
    localparam logic [2:0] R2   = 3'd5;

    localparam int GW = (NREG > 1) ? $clog2(NREG) : 1;
    // Word indices 0..3 are CTRL/STATUS/IRQ_STAT/IRQ_EN, GP[k] sits at 4+k.
    localparam logic [7:0] MAP_END = 8'(4 + NREG);

    logic [2:0]       state, state_nxt;
    logic [7:0]       waddr_q, raddr_q, roff;
    logic [31:0]      wdata_q, wmask, clr_full, rd_word, rdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       rresp_q;
    logic             b_first, commit, rd_mapped;
    logic [IRQ_N-1:0] irq_stat_q, irq_en_q, irq_clr;
    logic [31:0]      gp_q [NREG];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) state_nxt = B;
                else if (s_axi.S_AXI_AWVALID)                  state_nxt = WA;
                else if (s_axi.S_AXI_WVALID)                   state_nxt = WD;
                else if (s_axi.S_AXI_ARVALID)                  state_nxt = R1;
            end
            WA:      if (s_axi.S_AXI_WVALID)  state_nxt = B;
            WD:      if (s_axi.S_AXI_AWVALID) state_nxt = B;
            B:       if (s_axi.S_AXI_BREADY)  state_nxt = IDLE;
            R1:      state_nxt = R2;
            R2:      if (s_axi.S_AXI_RREADY)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_axi.S_AXI_AWREADY = (state == IDLE) || (state == WD);
    assign s_axi.S_AXI_WREADY  = (state == IDLE) || (state == WA);
    assign s_axi.S_AXI_ARREADY = (state == IDLE);
    assign s_axi.S_AXI_BVALID  = (state == B);
    assign s_axi.S_AXI_BRESP   = ((state == B) && (waddr_q >= MAP_END)) ? 2'b10 : 2'b00;
    assign s_axi.S_AXI_RVALID  = (state == R2);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    // b_first marks only the first B cycle so a stalled BREADY never re-commits.
    assign commit   = (state == B) && b_first;
    assign wmask    = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
    assign clr_full = (commit && (waddr_q == 8'd2)) ? (wdata_q & wmask) : 32'd0;
    assign irq_clr  = clr_full[IRQ_N-1:0];
    assign roff     = raddr_q - 8'd4;

    always_comb begin
        rd_word   = 32'd0;
        rd_mapped = 1'b1;
        case (raddr_q)
            8'd0: rd_word[2:0]        = ctrl;
            8'd1: rd_word[STAT_W-1:0] = status_in;
            8'd2: rd_word[IRQ_N-1:0]  = irq_stat_q;
            8'd3: rd_word[IRQ_N-1:0]  = irq_en_q;
            default: begin
                if (raddr_q < MAP_END) rd_word = gp_q[roff[GW-1:0]];
                else                   rd_mapped = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            b_first    <= 1'b0;
            waddr_q    <= 8'd0;
            raddr_q    <= 8'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            rdata_q    <= 32'd0;
            rresp_q    <= 2'b00;
            ctrl       <= 3'd0;
            start      <= 1'b0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            irq        <= 1'b0;
            for (int k = 0; k < NREG; k++) gp_q[k] <= 32'd0;
        end else begin
            state   <= state_nxt;
            b_first <= (state != B) && (state_nxt == B);
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY) waddr_q <= s_axi.S_AXI_AWADDR[9:2];
            if (s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY) begin
                wdata_q <= s_axi.S_AXI_WDATA;
                wstrb_q <= s_axi.S_AXI_WSTRB;
            end
            // ARREADY is high in IDLE, but a concurrent write wins the slot.
            if ((state == IDLE) && (state_nxt == R1)) raddr_q <= s_axi.S_AXI_ARADDR[9:2];
            if (state == R1) begin
                rdata_q <= rd_word;
                rresp_q <= rd_mapped ? 2'b00 : 2'b10;
            end

            start <= 1'b0;
            if (commit && (waddr_q == 8'd0) && wstrb_q[0]) begin
                ctrl  <= wdata_q[2:0];
                start <= wdata_q[3];
            end
            if (commit && (waddr_q == 8'd3))
                irq_en_q <= (irq_en_q & ~wmask[IRQ_N-1:0]) | (wdata_q[IRQ_N-1:0] & wmask[IRQ_N-1:0]);
            for (int k = 0; k < NREG; k++) begin
                if (commit && (waddr_q == 8'(4 + k))) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb_q[b]) gp_q[k][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_src;
            irq        <= |(irq_stat_q & irq_en_q);
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_gp_out
        assign gp_regs[32*k +: 32] = gp_q[k];
    end
endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Scoreboard bench for axil_ctrl_regs: expected read/write responses are queued at issue and popped on completion.
module tb_axil_ctrl_regs;
    localparam int NREG = 8, STAT_W = 8, IRQ_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]         ctrl;
    logic               start;
    logic [32*NREG-1:0] gp_regs;
    logic [STAT_W-1:0]  status_in;
    logic [IRQ_N-1:0]   irq_src;
    logic               irq;

    axil_ctrl_regs_if bus();

    axil_ctrl_regs #(.NREG(NREG), .STAT_W(STAT_W), .IRQ_N(IRQ_N)) dut (
        .clk(clk), .rst(rst), .s_axi(bus), .ctrl(ctrl), .start(start),
        .gp_regs(gp_regs), .status_in(status_in), .irq_src(irq_src), .irq(irq)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    rexp_t       rq[$];
    logic [1:0]  bq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_gp [NREG];
    logic [31:0] rd;
    logic [1:0]  rr, br, eb;
    int          lat;
    rexp_t       e;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [32*NREG-1:0] gp_vec();
        logic [32*NREG-1:0] v;
        for (int k = 0; k < NREG; k++) v[32*k +: 32] = m_gp[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Simultaneous AW+W; src_b drives irq_src during the first B cycle (the commit cycle).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [IRQ_N-1:0] src_b, output logic [1:0] resp);
        int n = 0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        while (!bus.S_AXI_BVALID && n < 20) begin tick(); n++; end
        if (!bus.S_AXI_BVALID) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h bvalid=%b required 1", addr, bus.S_AXI_BVALID);
        end
        resp    = bus.S_AXI_BRESP;
        irq_src = src_b;
        tick();
        irq_src = '0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int cyc);
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        cyc = 1;
        while (!bus.S_AXI_RVALID && cyc < 20) begin tick(); cyc++; end
        if (!bus.S_AXI_RVALID) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h rvalid=%b required 1", addr, bus.S_AXI_RVALID);
        end
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        rexp_t       exps  [3];
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_BREADY  = 1'b1; bus.S_AXI_RREADY = 1'b1;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_ARADDR = '0;
        status_in = 8'h5A; irq_src = '0;
        for (int k = 0; k < NREG; k++) m_gp[k] = 32'd0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, start, irq} !== 4'b0000) begin
            errors++; $display("FAIL reset_valids got %b required 0000", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, start, irq});
        end
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL reset_idle_readies got %b required 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        checks++;
        if (ctrl !== 3'd0 || gp_regs !== '0 || bus.S_AXI_RDATA !== 32'd0) begin
            errors++; $display("FAIL reset_regs ctrl=%b rdata=%h gp0=%h required zeros", ctrl, bus.S_AXI_RDATA, gp_regs[31:0]);
        end
        addrs[0] = 32'h000; exps[0] = '{d: 32'h0,  r: 2'b00};
        addrs[1] = 32'h004; exps[1] = '{d: 32'h5A, r: 2'b00};
        addrs[2] = 32'h010; exps[2] = '{d: 32'h0,  r: 2'b00};
        for (int i = 0; i < 3; i++) begin
            rq.push_back(exps[i]);
            axi_read(addrs[i], rd, rr, lat);
            e = rq.pop_front();
            checks++;
            if ({rd, rr} !== {e.d, e.r}) begin
                errors++; $display("FAIL reset_read addr=%h got %h/%b required %h/%b", addrs[i], rd, rr, e.d, e.r);
            end
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL read_latency addr=%h got %0d required 2", addrs[i], lat);
            end
        end
    endtask

    task automatic test_strobe_write();
        logic [31:0] d;
        logic [3:0]  s;
        bq.push_back(2'b00); m_gp[0] = 32'h11223344;
        axi_write(32'h010, 32'h11223344, 4'hF, '0, br);
        eb = bq.pop_front(); checks++;
        if (br !== eb) begin errors++; $display("FAIL gp0_init_bresp got %b required %b", br, eb); end
        bq.push_back(2'b00); m_gp[0] = merge(m_gp[0], 32'hA5A5A5A5, 4'b0101);
        axi_write(32'h010, 32'hA5A5A5A5, 4'b0101, '0, br);
        eb = bq.pop_front(); checks++;
        if (br !== eb) begin errors++; $display("FAIL strobe_bresp got %b required %b", br, eb); end
        checks++;
        if (gp_regs[31:0] !== 32'h11A533A5) begin
            errors++; $display("FAIL strobe_gp0 got %h required 11a533a5", gp_regs[31:0]);
        end
        for (int k = 0; k < NREG; k++) begin
            d = $urandom; s = 4'($urandom_range(1, 15));
            m_gp[k] = merge(m_gp[k], d, s);
            axi_write(32'h010 + 32'(4 * k), d, s, '0, br);
        end
        checks++;
        if (gp_regs !== gp_vec()) begin errors++; $display("FAIL gp_vector got %h required %h", gp_regs, gp_vec()); end
        for (int k = 0; k < NREG; k++) begin
            rq.push_back('{d: m_gp[k], r: 2'b00});
            axi_read(32'h010 + 32'(4 * k), rd, rr, lat);
            e = rq.pop_front(); checks++;
            if ({rd, rr} !== {e.d, e.r}) begin
                errors++; $display("FAIL gp_readback k=%0d got %h/%b required %h/%b", k, rd, rr, e.d, e.r);
            end
        end
    endtask

    task automatic test_split_write();
        int bv_cnt = 0, st_cnt = 0;
        bus.S_AXI_AWADDR = 32'h000; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 3'b010) begin
            errors++; $display("FAIL wa_state got %b required 010", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID});
        end
        repeat (2) tick();
        bus.S_AXI_WDATA = 32'hF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.S_AXI_BVALID) bv_cnt++;
            if (start) st_cnt++;
            if (i == 4) bus.S_AXI_BREADY = 1'b1;
            tick();
        end
        if (start) st_cnt++;
        checks++;
        if (bv_cnt !== 5) begin errors++; $display("FAIL bvalid_cycles got %0d required 5", bv_cnt); end
        checks++;
        if (st_cnt !== 1) begin errors++; $display("FAIL start_cycles got %0d required 1", st_cnt); end
        checks++;
        if ({bus.S_AXI_BVALID, ctrl} !== 4'b0111) begin
            errors++; $display("FAIL ctrl_after_split got %b required 0111", {bus.S_AXI_BVALID, ctrl});
        end
        rq.push_back('{d: 32'h7, r: 2'b00});
        axi_read(32'h000, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL ctrl_readback got %h/%b required %h/%b", rd, rr, e.d, e.r); end
        // Strobe without byte 0: no start, no ctrl change.
        axi_write(32'h000, 32'h8, 4'hE, '0, br);
        checks++;
        if ({start, ctrl} !== 4'b0111) begin errors++; $display("FAIL ctrl_nostrobe got %b required 0111", {start, ctrl}); end
        axi_write(32'h000, 32'hF, 4'h1, '0, br);
        checks++;
        if ({start, ctrl} !== 4'b1111) begin errors++; $display("FAIL start_pulse got %b required 1111", {start, ctrl}); end
        tick();
        checks++;
        if (start !== 1'b0) begin errors++; $display("FAIL start_clear got %b required 0", start); end
        // Data-first write to GP1.
        bus.S_AXI_WDATA = 32'h0BADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_WVALID = 1'b0;
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b10) begin
            errors++; $display("FAIL wd_state got %b required 10", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY});
        end
        bus.S_AXI_AWADDR = 32'h014; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        tick();
        m_gp[1] = 32'h0BADBEEF;
        checks++;
        if (gp_regs[63:32] !== m_gp[1]) begin errors++; $display("FAIL wd_commit got %h required %h", gp_regs[63:32], m_gp[1]); end
    endtask

    task automatic test_irq();
        axi_write(32'h00C, 32'h4, 4'hF, '0, br);
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b required 0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b required 1", irq); end
        for (int i = 0; i < 2; i++) begin
            rq.push_back('{d: 32'h4, r: 2'b00});
            axi_read(32'h008, rd, rr, lat);
            e = rq.pop_front(); checks++;
            if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL irq_stat_read%0d got %h/%b required %h/%b", i, rd, rr, e.d, e.r); end
        end
        axi_write(32'h008, 32'h4, 4'hF, 4'b0100, br);
        rq.push_back('{d: 32'h4, r: 2'b00});
        axi_read(32'h008, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr, irq} !== {e.d, e.r, 1'b1}) begin
            errors++; $display("FAIL set_wins got %h/%b irq=%b required %h/%b irq=1", rd, rr, irq, e.d, e.r);
        end
        axi_write(32'h008, 32'h4, 4'hF, '0, br);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_on_clear got %b required 1", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b required 0", irq); end
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        axi_write(32'h008, 32'hFFFFFFFF, 4'b0000, '0, br);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b required 0", irq); end
        rq.push_back('{d: 32'h1, r: 2'b00});
        axi_read(32'h008, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL w1c_nostrobe got %h/%b required %h/%b", rd, rr, e.d, e.r); end
        axi_write(32'h00C, 32'hFFFFFFFF, 4'hF, '0, br);
        rq.push_back('{d: 32'hF, r: 2'b00});
        axi_read(32'h00C, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL irq_en_width got %h/%b required %h/%b", rd, rr, e.d, e.r); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_enabled got %b required 1", irq); end
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [2];
        addrs[0] = 32'h3F0; addrs[1] = 32'h030;
        for (int i = 0; i < 2; i++) begin
            bq.push_back(2'b10);
            axi_write(addrs[i], 32'hDEADBEEF, 4'hF, '0, br);
            eb = bq.pop_front(); checks++;
            if (br !== eb) begin errors++; $display("FAIL unmapped_bresp addr=%h got %b required %b", addrs[i], br, eb); end
            rq.push_back('{d: 32'h0, r: 2'b10});
            axi_read(addrs[i], rd, rr, lat);
            e = rq.pop_front(); checks++;
            if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL unmapped_read addr=%h got %h/%b required %h/%b", addrs[i], rd, rr, e.d, e.r); end
        end
        checks++;
        if (gp_regs !== gp_vec() || ctrl !== 3'b111) begin
            errors++; $display("FAIL unmapped_side_effect gp0=%h ctrl=%b required %h/111", gp_regs[31:0], ctrl, m_gp[0]);
        end
        status_in = 8'hC3;
        bq.push_back(2'b00);
        axi_write(32'h004, 32'hFFFFFFFF, 4'hF, '0, br);
        eb = bq.pop_front(); checks++;
        if (br !== eb) begin errors++; $display("FAIL status_write_bresp got %b required %b", br, eb); end
        rq.push_back('{d: 32'hC3, r: 2'b00});
        axi_read(32'h404, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL status_alias got %h/%b required %h/%b", rd, rr, e.d, e.r); end
        m_gp[0] = 32'h55AA55AA;
        axi_write(32'h410, 32'h55AA55AA, 4'hF, '0, br);
        checks++;
        if (gp_regs[31:0] !== m_gp[0]) begin errors++; $display("FAIL gp_alias_write got %h required %h", gp_regs[31:0], m_gp[0]); end
        rq.push_back('{d: m_gp[1], r: 2'b00});
        axi_read(32'hFFFFF414, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL gp_alias_read got %h/%b required %h/%b", rd, rr, e.d, e.r); end
    endtask

    task automatic test_reset_midflight();
        bus.S_AXI_AWADDR = 32'h018; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.S_AXI_WVALID = 1'b0;
        for (int k = 0; k < NREG; k++) m_gp[k] = 32'd0;
        checks++;
        if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID, ctrl, irq} !== 6'd0) begin
            errors++; $display("FAIL rst_in_wa got %b required 000000", {bus.S_AXI_BVALID, bus.S_AXI_RVALID, ctrl, irq});
        end
        checks++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL rst_wa_idle got %b required 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
        end
        repeat (3) tick();
        checks++;
        if (gp_regs !== gp_vec()) begin errors++; $display("FAIL rst_dropped_write got %h required %h", gp_regs[95:64], m_gp[2]); end
        m_gp[0] = 32'h77;
        axi_write(32'h010, 32'h77, 4'hF, '0, br);
        bus.S_AXI_ARADDR = 32'h010; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        tick();
        checks++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RDATA} !== {1'b1, m_gp[0]}) begin
            errors++; $display("FAIL r2_before_rst got %b/%h required 1/%h", bus.S_AXI_RVALID, bus.S_AXI_RDATA, m_gp[0]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.S_AXI_RREADY = 1'b1;
        for (int k = 0; k < NREG; k++) m_gp[k] = 32'd0;
        checks++;
        if ({bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_ARREADY} !== {1'b0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL rst_in_r2 got %b/%h/%b required 0/00000000/1", bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_ARREADY);
        end
        rq.push_back('{d: 32'h0, r: 2'b00});
        axi_read(32'h010, rd, rr, lat);
        e = rq.pop_front(); checks++;
        if ({rd, rr} !== {e.d, e.r}) begin errors++; $display("FAIL post_rst_read got %h/%b required %h/%b", rd, rr, e.d, e.r); end
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_split_write();
        test_irq();
        test_unmapped();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
